lab5_mcore_mem_arbiter: RTL and testbench

LAB5_MCORE_MEM_ARBITER -- requirements
Module: lab5_mcore_mem_arbiter

---
 rtl/lab5_mcore_mem_arbiter.sv | 111 +++++++++++
 tb/tb_lab5_mcore_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab5_mcore_mem_arbiter.sv
// N-port memory arbiter: round-robin or fixed-priority grant onto one main-memory port,
// with an in-order port-ID FIFO steering responses back to their requester.
module lab5_mcore_mem_arbiter #(
  parameter int p_num_ports       = 4,
  parameter int p_max_outstanding = 4,
  parameter int p_arb_mode        = 0,
  parameter int p_req_w           = 177,
  parameter int p_resp_w          = 145
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [p_num_ports-1:0][p_req_w-1:0]   req_msg,
  input  logic [p_num_ports-1:0]                req_val,
  output logic [p_num_ports-1:0]                req_rdy,
  output logic [p_num_ports-1:0][p_resp_w-1:0]  resp_msg,
  output logic [p_num_ports-1:0]                resp_val,
  input  logic [p_num_ports-1:0]                resp_rdy,
  output logic [p_req_w-1:0]                    mainreq_msg,
  output logic                                  mainreq_val,
  input  logic                                  mainreq_rdy,
  input  logic [p_resp_w-1:0]                   mainresp_msg,
  input  logic                                  mainresp_val,
  output logic                                  mainresp_rdy,
  output logic [$clog2(p_max_outstanding+1)-1:0] outstanding,
  output logic [p_num_ports-1:0]                grant_pulse
);
  localparam int id_w  = $clog2(p_num_ports);
  localparam int ptr_w = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
  localparam int cnt_w = $clog2(p_max_outstanding+1);

  logic [id_w-1:0]  rr_ptr, grant, head_id;
  logic [ptr_w-1:0] wr_ptr, rd_ptr;
  logic [cnt_w-1:0] count;
  logic [id_w-1:0]  fifo [p_max_outstanding];
  logic             any_val, full, empty, req_fire, resp_fire;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(p_max_outstanding-1)) ? '0 : p + 1'b1;
  endfunction

  assign any_val = |req_val;
  assign full    = (count == cnt_w'(p_max_outstanding));
  assign empty   = (count == '0);
  assign head_id = fifo[rd_ptr];

  always_comb begin
    logic            found;
    logic [id_w-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (p_arb_mode == 1) begin
      for (int i = p_num_ports-1; i >= 0; i--)
        if (req_val[i]) grant = id_w'(i);
    end else begin
      for (int i = 0; i < p_num_ports; i++) begin
        idx = id_w'((int'(rr_ptr) + i) % p_num_ports);
        if (!found && req_val[idx]) begin
          grant = idx;
          found = 1'b1;
        end
      end
    end
  end

  // Ready only depends on mainreq_rdy and FIFO space, never on response-side readies.
  always_comb begin
    req_rdy = '0;
    if (any_val) req_rdy[grant] = mainreq_rdy & ~full;
  end

  assign mainreq_msg = req_msg[grant];
  assign mainreq_val = any_val & ~full;
  assign req_fire    = mainreq_val & mainreq_rdy;

  always_comb begin
    resp_val = '0;
    for (int k = 0; k < p_num_ports; k++) resp_msg[k] = mainresp_msg;
    if (!empty && mainresp_val) resp_val[head_id] = 1'b1;
  end

  assign mainresp_rdy = ~empty & resp_rdy[head_id];
  assign resp_fire    = mainresp_val & mainresp_rdy;
  assign outstanding  = count;

  always_ff @(posedge clk)
    if (req_fire) fifo[wr_ptr] <= grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      grant_pulse <= '0;
    end else begin
      grant_pulse <= '0;
      if (req_fire) begin
        wr_ptr             <= ptr_inc(wr_ptr);
        rr_ptr             <= (grant == id_w'(p_num_ports-1)) ? '0 : grant + 1'b1;
        grant_pulse[grant] <= 1'b1;
      end
      if (resp_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({req_fire, resp_fire})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_lab5_mcore_mem_arbiter.sv
// Random-stimulus bench: two arbiters (round-robin depth 4, fixed-priority depth 2) against
// a queue-based reference model, with a scoreboard of expected responses per requester.
module tb_lab5_mcore_mem_arbiter;
  localparam int N   = 4;
  localparam int RQW = 177;
  localparam int RSW = 145;
  localparam int ND  = 2;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0][RQW-1:0] req_msg;
  logic [N-1:0]          req_val, resp_rdy;
  logic                  mainreq_rdy;

  logic [N-1:0]          req_rdy_d  [ND];
  logic [N-1:0]          resp_val_d [ND];
  logic [N-1:0]          gp_d       [ND];
  logic [N-1:0][RSW-1:0] resp_msg_d [ND];
  logic [RQW-1:0]        mreq_msg_d [ND];
  logic                  mreq_val_d [ND];
  logic                  mresp_rdy_d[ND];
  logic                  mresp_val_d[ND];
  logic [RSW-1:0]        mresp_msg_d[ND];
  logic [2:0]            outs0;
  logic [1:0]            outs1;

  int             m_rr  [ND];
  int             m_ids [ND][$];
  logic [RSW-1:0] mem_q [ND][$];
  int             sb_port[ND][$];
  logic [RSW-1:0] sb_msg [ND][$];
  logic [N-1:0]   exp_pulse[ND];
  logic           rst_prev = 1'b0;
  int             n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  lab5_mcore_mem_arbiter #(.p_num_ports(N), .p_max_outstanding(4), .p_arb_mode(0)) u_rr (
    .clk(clk), .reset(reset), .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy_d[0]),
    .resp_msg(resp_msg_d[0]), .resp_val(resp_val_d[0]), .resp_rdy(resp_rdy),
    .mainreq_msg(mreq_msg_d[0]), .mainreq_val(mreq_val_d[0]), .mainreq_rdy(mainreq_rdy),
    .mainresp_msg(mresp_msg_d[0]), .mainresp_val(mresp_val_d[0]), .mainresp_rdy(mresp_rdy_d[0]),
    .outstanding(outs0), .grant_pulse(gp_d[0]));

  lab5_mcore_mem_arbiter #(.p_num_ports(N), .p_max_outstanding(2), .p_arb_mode(1)) u_fp (
    .clk(clk), .reset(reset), .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy_d[1]),
    .resp_msg(resp_msg_d[1]), .resp_val(resp_val_d[1]), .resp_rdy(resp_rdy),
    .mainreq_msg(mreq_msg_d[1]), .mainreq_val(mreq_val_d[1]), .mainreq_rdy(mainreq_rdy),
    .mainresp_msg(mresp_msg_d[1]), .mainresp_val(mresp_val_d[1]), .mainresp_rdy(mresp_rdy_d[1]),
    .outstanding(outs1), .grant_pulse(gp_d[1]));

  function automatic logic [RQW-1:0] rnd_bits();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[RQW-1:0];
  endfunction

  task automatic chk(input string nm, input int d, input logic [RQW-1:0] act, input logic [RQW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, d, $time, act, exp);
  endtask

  // Memory response for a request: same type/opaque/len, fresh random data.
  function automatic logic [RSW-1:0] mk_resp(input logic [RQW-1:0] rq);
    logic [127:0] dat;
    dat = {$urandom, $urandom, $urandom, $urandom};
    return {rq[176:174], rq[173:166], 2'b00, rq[131:128], dat};
  endfunction

  task automatic clear_model(input int d);
    m_rr[d] = 0;
    m_ids[d].delete();
    mem_q[d].delete();
    sb_port[d].delete();
    sb_msg[d].delete();
    exp_pulse[d] = '0;
  endtask

  task automatic check_dut(input int d);
    int maxo, mode, cnt, g, head, outs, p;
    logic any, full, empty, same;
    logic [N-1:0] exp_rdy, exp_rv;
    logic [RSW-1:0] rmsg, m;
    maxo = (d == 0) ? 4 : 2;
    mode = (d == 0) ? 0 : 1;
    outs = (d == 0) ? int'(outs0) : int'(outs1);
    if (reset) begin
      if (rst_prev)
        chk("reset_outputs", d, {gp_d[d], req_rdy_d[d], resp_val_d[d], mreq_val_d[d], mresp_rdy_d[d], 3'(outs)}, '0);
      clear_model(d);
      return;
    end
    cnt   = m_ids[d].size();
    any   = |req_val;
    full  = (cnt == maxo);
    empty = (cnt == 0);
    g = -1;
    for (int i = 0; i < N; i++) begin
      p = (mode == 1) ? i : (m_rr[d] + i) % N;
      if (g < 0 && req_val[p]) g = p;
    end
    chk("outstanding", d, RQW'(outs), RQW'(cnt));
    chk("grant_pulse", d, RQW'(gp_d[d]), RQW'(exp_pulse[d]));
    chk("mainreq_val", d, RQW'(mreq_val_d[d]), RQW'(any && !full));
    exp_rdy = '0;
    if (any) exp_rdy[g] = mainreq_rdy && !full;
    chk("req_rdy", d, RQW'(req_rdy_d[d]), RQW'(exp_rdy));
    if (any) chk("mainreq_msg", d, mreq_msg_d[d], req_msg[g]);
    head = empty ? 0 : m_ids[d][0];
    chk("mainresp_rdy", d, RQW'(mresp_rdy_d[d]), RQW'(!empty && resp_rdy[head]));
    exp_rv = '0;
    if (!empty && mresp_val_d[d]) exp_rv[head] = 1'b1;
    chk("resp_val", d, RQW'(resp_val_d[d]), RQW'(exp_rv));
    same = 1'b1;
    for (int k = 0; k < N; k++) if (resp_msg_d[d][k] !== mresp_msg_d[d]) same = 1'b0;
    chk("resp_bcast", d, RQW'(same), RQW'(1));
    // Scoreboard: consume whatever the DUT actually delivers this cycle.
    for (int k = 0; k < N; k++) begin
      if (resp_val_d[d][k] && resp_rdy[k]) begin
        if (sb_port[d].size() == 0) chk("resp_unexpected", d, RQW'(k + 1), RQW'(0));
        else begin
          p = sb_port[d].pop_front();
          m = sb_msg[d].pop_front();
          chk("resp_port", d, RQW'(k), RQW'(p));
          chk("resp_msg", d, RQW'(resp_msg_d[d][k]), RQW'(m));
        end
      end
    end
    exp_pulse[d] = '0;
    if (!empty && mresp_val_d[d] && resp_rdy[head]) begin
      void'(m_ids[d].pop_front());
      void'(mem_q[d].pop_front());
    end
    if (any && !full && mainreq_rdy) begin
      rmsg = mk_resp(req_msg[g]);
      m_ids[d].push_back(g);
      mem_q[d].push_back(rmsg);
      sb_port[d].push_back(g);
      sb_msg[d].push_back(rmsg);
      m_rr[d] = (g + 1) % N;
      exp_pulse[d][g] = 1'b1;
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < ND; d++) check_dut(d);
    rst_prev = reset;
  end

  task automatic drive_zero();
    req_val     = '0;
    req_msg     = '0;
    resp_rdy    = '0;
    mainreq_rdy = 1'b0;
    for (int d = 0; d < ND; d++) begin
      mresp_val_d[d] = 1'b0;
      mresp_msg_d[d] = '0;
    end
  endtask

  task automatic drive_mem(input int bias);
    for (int d = 0; d < ND; d++) begin
      if (mem_q[d].size() > 0) begin
        mresp_val_d[d] = ($urandom_range(0, 3) < bias);
        mresp_msg_d[d] = mem_q[d][0];
      end else begin
        // Stray response with nothing in flight: must be ignored.
        mresp_val_d[d] = 1'($urandom_range(0, 1));
        mresp_msg_d[d] = RSW'(rnd_bits());
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset = 1'b1; drive_zero();
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b0; drive_zero();
  endtask

  initial begin
    reset = 1'b1;
    drive_zero();
    for (int d = 0; d < ND; d++) clear_model(d);
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    // All ports valid, main memory always ready, no responses: rotation then stall on full.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      req_val     = '1;
      mainreq_rdy = 1'b1;
      resp_rdy    = '0;
      for (int k = 0; k < N; k++) req_msg[k] = rnd_bits();
      for (int d = 0; d < ND; d++) begin
        mresp_val_d[d] = 1'b0;
        mresp_msg_d[d] = '0;
      end
    end
    // Ports 1 and 3 only, with responses draining.
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      req_val     = 4'b1010;
      mainreq_rdy = 1'b1;
      resp_rdy    = '1;
      for (int k = 0; k < N; k++) req_msg[k] = rnd_bits();
      drive_mem(4);
    end
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      @(posedge clk); #1;
      req_val     = N'($urandom);
      mainreq_rdy = ($urandom_range(0, 3) != 0);
      resp_rdy    = N'($urandom) | N'($urandom);
      for (int k = 0; k < N; k++) req_msg[k] = rnd_bits();
      drive_mem(3);
    end
    @(posedge clk); #1;
    drive_zero();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
